// File: rtl/fios_sched_pkg.sv
// rtl/fios_sched_pkg.sv - shared word width, FSM state and requester-id types for the FIOS scheduler
package fios_sched_pkg;

  localparam int WORD_W = 17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    RUN   = 2'd3
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/fios_rr_arb.sv
// rtl/fios_rr_arb.sv - 2-way round-robin arbiter; pointer moves past the served requester on update
module fios_rr_arb
  import fios_sched_pkg::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [1:0] req,
  input  logic       update,
  input  req_id_t    served,
  output logic       any,
  output req_id_t    gnt_id
);

  req_id_t prio;

  always_comb begin
    any    = |req;
    gnt_id = (req == 2'b11) ? prio : req[1];
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      prio <= 1'b0;
    end else if (update) begin
      prio <= ~served;
    end
  end

endmodule

// File: rtl/fios_mm_sched.sv
// rtl/fios_mm_sched.sv - job scheduler feeding operand words to a FIOS Montgomery multiplier
// Optional watchdog on the RUN state is built when FIOS_SCHED_WDOG_EN is defined.
module fios_mm_sched
  import fios_sched_pkg::*;
#(
  parameter int S           = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [1:0]        req_i,
  output logic [1:0]        gnt_o,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  logic [WORD_W-1:0] ld_b_i,
  input  logic [WORD_W-1:0] ld_p_i,
  output logic              mm_start_o,
  input  logic              b_fetch_i,
  input  logic              p_fetch_i,
  output logic [WORD_W-1:0] b_o,
  output logic [WORD_W-1:0] p_o,
  input  logic              res_push_i,
  input  logic [WORD_W-1:0] res_i,
  input  logic              done_i,
  output logic              res_valid_o,
  output logic [WORD_W-1:0] res_data_o,
  output logic              res_id_o,
  output logic              res_last_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int IW = (S > 1) ? $clog2(S) : 1;
  localparam int CW = $clog2(S + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(S - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(S - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(S);

  state_t            state_q, state_d;
  logic [1:0]        gnt_q;
  req_id_t           id_q;
  logic [WORD_W-1:0] b_buf [S];
  logic [WORD_W-1:0] p_buf [S];
  logic [IW-1:0]     ld_idx, b_idx, p_idx;
  logic [CW-1:0]     push_cnt;
  logic              arb_any, arb_upd;
  req_id_t           arb_id;
  logic              beat, in_run, timeout, stray;

  assign ld_ready_o = (state_q == LOAD);
  assign mm_start_o = (state_q == START);
  assign busy_o     = (state_q != IDLE);
  assign gnt_o      = gnt_q;
  assign b_o        = b_buf[b_idx];
  assign p_o        = p_buf[p_idx];
  assign beat       = ld_valid_i && ld_ready_o;
  assign in_run     = (state_q == RUN);
  assign stray      = !in_run && (b_fetch_i || p_fetch_i || res_push_i || done_i);

  fios_rr_arb u_arb (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .req     (req_i),
    .update  (arb_upd),
    .served  (id_q),
    .any     (arb_any),
    .gnt_id  (arb_id)
  );

`ifdef FIOS_SCHED_WDOG_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wd_cnt;

  // START counts as the first watched cycle, so IDLE is reached TIMEOUT_CYC cycles after START
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      wd_cnt <= '0;
    end else if (state_q == START) begin
      wd_cnt <= TW'(1);
    end else if (in_run) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign timeout = in_run && !done_i && (wd_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    arb_upd = 1'b0;
    case (state_q)
      IDLE:    if (arb_any) state_d = LOAD;
      LOAD:    if (beat && (ld_idx == IDX_LAST)) state_d = START;
      START:   state_d = RUN;
      RUN: begin
        if (done_i || timeout) begin
          state_d = IDLE;
          arb_upd = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand storage is intentionally not reset; it is fully rewritten by every job
  always_ff @(posedge clock_i) begin
    if (beat) begin
      b_buf[ld_idx] <= ld_b_i;
      p_buf[ld_idx] <= ld_p_i;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      gnt_q       <= 2'b00;
      id_q        <= 1'b0;
      ld_idx      <= '0;
      b_idx       <= '0;
      p_idx       <= '0;
      push_cnt    <= '0;
      res_valid_o <= 1'b0;
      res_data_o  <= '0;
      res_id_o    <= 1'b0;
      res_last_o  <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      if (state_q == IDLE && arb_any) begin
        gnt_q  <= {arb_id, ~arb_id};
        id_q   <= arb_id;
        ld_idx <= '0;
      end
      if (in_run && state_d == IDLE) begin
        gnt_q <= 2'b00;
      end
      if (beat) begin
        ld_idx <= (ld_idx == IDX_LAST) ? '0 : ld_idx + 1'b1;
      end
      if (state_q == START) begin
        b_idx    <= '0;
        p_idx    <= '0;
        push_cnt <= '0;
      end
      if (in_run && b_fetch_i) begin
        b_idx <= (b_idx == IDX_LAST) ? '0 : b_idx + 1'b1;
      end
      if (in_run && p_fetch_i) begin
        p_idx <= (p_idx == IDX_LAST) ? '0 : p_idx + 1'b1;
      end

      res_valid_o <= in_run && res_push_i;
      res_last_o  <= in_run && res_push_i && (push_cnt == CNT_LAST);
      if (in_run && res_push_i) begin
        res_data_o <= res_i;
        res_id_o   <= id_q;
        // Saturate so any overflow push keeps being flagged
        if (push_cnt != CNT_FULL) push_cnt <= push_cnt + 1'b1;
      end

      if (stray || timeout || (in_run && res_push_i && push_cnt == CNT_FULL)) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fios_mm_sched.sv
// tb/tb_fios_mm_sched.sv - scoreboard bench for fios_mm_sched; watchdog case runs when FIOS_SCHED_WDOG_EN is defined
`timescale 1ns/1ps
module tb_fios_mm_sched;

`ifdef FIOS_SCHED_WDOG_EN
  localparam int TO = 16;
`else
  localparam int TO = 4096;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic        ld_valid, ld_ready;
  logic [16:0] ld_b, ld_p;
  logic        mm_start, b_fetch, p_fetch;
  logic [16:0] b_w, p_w;
  logic        res_push, done;
  logic [16:0] res_in;
  logic        res_valid, res_id, res_last, busy, err;
  logic [16:0] res_data;

  int checks = 0;
  int errors = 0;
  logic [18:0] exp_q [$];

  always #5 clk = ~clk;

  fios_mm_sched #(.S(8), .TIMEOUT_CYC(TO)) dut (
    .clock_i     (clk),
    .reset_i     (rst_n),
    .req_i       (req),
    .gnt_o       (gnt),
    .ld_valid_i  (ld_valid),
    .ld_ready_o  (ld_ready),
    .ld_b_i      (ld_b),
    .ld_p_i      (ld_p),
    .mm_start_o  (mm_start),
    .b_fetch_i   (b_fetch),
    .p_fetch_i   (p_fetch),
    .b_o         (b_w),
    .p_o         (p_w),
    .res_push_i  (res_push),
    .res_i       (res_in),
    .done_i      (done),
    .res_valid_o (res_valid),
    .res_data_o  (res_data),
    .res_id_o    (res_id),
    .res_last_o  (res_last),
    .busy_o      (busy),
    .err_o       (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result monitor: each DUT result beat is compared against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL res_unexpected: got %0h expected none", {res_last, res_id, res_data});
      end else begin
        chk("res_beat", {13'd0, res_last, res_id, res_data}, {13'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic load_job(input logic [16:0] b0, input logic [16:0] p0);
    for (int i = 0; i < 8; i++) begin
      chk("ld_ready", 32'(ld_ready), 32'd1);
      ld_valid = 1'b1;
      ld_b     = b0 + 17'(i);
      ld_p     = p0 + 17'(i);
      tick();
    end
    ld_valid = 1'b0;
    chk("mm_start_hi", 32'(mm_start), 32'd1);
    chk("ld_ready_lo", 32'(ld_ready), 32'd0);
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic push(input logic [16:0] d, input logic id, input logic last);
    exp_q.push_back({last, id, d});
    res_push = 1'b1;
    res_in   = d;
    tick();
    res_push = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req = 2'b00; ld_valid = 1'b0; ld_b = '0; ld_p = '0;
    b_fetch = 1'b0; p_fetch = 1'b0; res_push = 1'b0; res_in = '0; done = 1'b0;
    tick(); tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    rst_n = 1'b1;

    // Job 1: requester 0, b = 1..8, p = 0x10..0x17
    req = 2'b01;
    tick();
    chk("j1_gnt", 32'(gnt), 32'd1);
    chk("j1_busy", 32'(busy), 32'd1);
    load_job(17'd1, 17'h10);
    chk("j1_busy_start", 32'(busy), 32'd1);
    tick();
    chk("j1_start_lo", 32'(mm_start), 32'd0);
    req = 2'b00;
    for (int i = 0; i < 9; i++) begin
      chk("b_seq", 32'(b_w), (i < 8) ? 32'(i + 1) : 32'd1);
      b_fetch = 1'b1;
      tick();
      b_fetch = 1'b0;
    end
    chk("p_first", 32'(p_w), 32'h10);
    p_fetch = 1'b1;
    tick();
    p_fetch = 1'b0;
    chk("p_second", 32'(p_w), 32'h11);
    for (int i = 0; i < 8; i++) push(17'h100 + 17'(i), 1'b0, i == 7);
    chk("err_before_extra", 32'(err), 32'd0);
    push(17'h1ff, 1'b0, 1'b0);
    chk("err_extra_push", 32'(err), 32'd1);
    pulse_done();
    chk("j1_gnt_clear", 32'(gnt), 32'd0);
    chk("j1_idle", 32'(busy), 32'd0);

    // Round robin from a fresh reset
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("rr_err_cleared", 32'(err), 32'd0);
    req = 2'b11;
    tick();
    chk("rr_first", 32'(gnt), 32'd1);
    load_job(17'h20, 17'h30);
    tick();
    pulse_done();
    chk("rr_gap", 32'(gnt), 32'd0);
    tick();
    chk("rr_second", 32'(gnt), 32'd2);
    tick(); tick();
    req = 2'b00;
    for (int i = 0; i < 6; i++) begin
      ld_valid = 1'b1; ld_b = 17'(i); ld_p = 17'(i); tick();
    end
    ld_valid = 1'b0;
    tick();
    chk("drop_req_ldready", 32'(ld_ready), 32'd1);
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; tick();
    end
    ld_valid = 1'b0;
    chk("drop_req_start", 32'(mm_start), 32'd1);
    tick();
    push(17'h0aa, 1'b1, 1'b0);
    pulse_done();
    tick();
    chk("rr_no_req", 32'(gnt), 32'd0);
    req = 2'b11;
    tick();
    chk("rr_third", 32'(gnt), 32'd1);
    chk("rr_err_clean", 32'(err), 32'd0);
    req = 2'b00;
    load_job(17'h40, 17'h50);
    tick();
    pulse_done();
    tick();

    // Stray done in IDLE
    pulse_done();
    chk("stray_done_err", 32'(err), 32'd1);
    chk("stray_done_gnt", 32'(gnt), 32'd0);

    // Reset while in RUN
    req = 2'b01;
    tick();
    req = 2'b00;
    load_job(17'h60, 17'h70);
    tick();
    chk("run_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_start", 32'(mm_start), 32'd0);
    chk("mid_rst_id", 32'(res_id), 32'd0);
    chk("mid_rst_last", 32'(res_last), 32'd0);
    tick();
    rst_n = 1'b1;

`ifdef FIOS_SCHED_WDOG_EN
    req = 2'b01;
    tick();
    req = 2'b00;
    load_job(17'h1, 17'h2);
    repeat (15) tick();
    chk("wd_still_busy", 32'(busy), 32'd1);
    tick();
    chk("wd_idle", 32'(busy), 32'd0);
    chk("wd_err", 32'(err), 32'd1);
    chk("wd_gnt", 32'(gnt), 32'd0);
`endif

    tick(); tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fios_mm_sched.md
FIOS_MM_SCHED -- requirements
Module: fios_mm_sched

Interface
REQ-001 Parameter S, default 8, number of 17-bit words per operand; SHALL be 2..64.
REQ-002 Parameter TIMEOUT_CYC, default 4096, watchdog limit in cycles, used only when FIOS_SCHED_WDOG_EN is defined.
REQ-003 clock_i  in  1  sole clock; all state on rising edge.
REQ-004 reset_i  in  1  asynchronous, active-low reset.
REQ-005 req_i  in  2  job request per requester, level.
REQ-006 gnt_o  out  2  one-hot grant, held for the whole job.
REQ-007 ld_valid_i / ld_ready_o  in/out  1/1  operand load handshake from the granted requester.
REQ-008 ld_b_i, ld_p_i  in  17 each  one b word and one p word per accepted beat, LSW first.
REQ-009 mm_start_o  out  1  start pulse to the multiplier.
REQ-010 b_fetch_i, p_fetch_i  in  1 each  word-fetch strobes from the multiplier.
REQ-011 b_o, p_o  out  17 each  current b/p word to the multiplier.
REQ-012 res_push_i, res_i, done_i  in  1/17/1  multiplier result strobe, word, completion.
REQ-013 res_valid_o, res_data_o, res_id_o, res_last_o  out  1/17/1/1  result stream to the requester; no backpressure.
REQ-014 busy_o, err_o  out  1 each  job in flight; sticky protocol/timeout error.

Function
REQ-015 FSM states: IDLE, LOAD, START, RUN.
REQ-016 IDLE: with any req_i high, the arbiter SHALL grant next cycle and move to LOAD; with both high, it SHALL grant the requester not served last (round-robin; requester 0 after reset).
REQ-017 LOAD: ld_ready_o=1; each ld_valid_i&ld_ready_o beat writes buffer[ld_idx]; after beat S-1, ld_ready_o SHALL drop the same cycle and the FSM SHALL go to START.
REQ-018 START: mm_start_o high exactly one cycle, then RUN; latency from last load beat to mm_start_o is 1 cycle.
REQ-019 b_o = b_buf[b_idx], p_o = p_buf[p_idx], with registered indices; b_idx/p_idx SHALL reset to 0 at START and increment on each b_fetch_i/p_fetch_i, wrapping S-1 -> 0.
REQ-020 Results: res_valid_o/res_data_o SHALL be res_push_i/res_i registered one cycle; res_id_o = granted requester; res_last_o on the S-th push.
REQ-021 A res_push_i after the S-th push in a job SHALL set err_o and be forwarded without res_last_o.
REQ-022 RUN: done_i SHALL return the FSM to IDLE next cycle, clear gnt_o, and update the round-robin pointer.
REQ-023 Dropping req_i mid-job SHALL be ignored; the job completes.
REQ-024 b_fetch_i, p_fetch_i, res_push_i or done_i outside RUN SHALL set err_o and be otherwise ignored.
REQ-025 busy_o SHALL be high in LOAD, START and RUN.
REQ-026 err_o SHALL clear only on reset.

Reset
REQ-027 Reset asserted: FSM=IDLE, gnt_o=0, ld_ready_o=0, mm_start_o=0, res_valid_o=0, res_last_o=0, res_id_o=0, busy_o=0, err_o=0, indices/counters=0, RR pointer favours requester 0.
REQ-028 Buffer contents are not reset; b_o/p_o are don't-care until the first START.
REQ-029 Reset mid-job SHALL abort with no further outputs; the multiplier is reset by the same reset.

Configuration
REQ-030 FIOS_SCHED_WDOG_EN defined: a counter starts at START; reaching TIMEOUT_CYC in RUN without done_i SHALL set err_o, drop gnt_o and return to IDLE.
REQ-031 Macro undefined: no watchdog logic; RUN waits indefinitely for done_i.

Structure
REQ-032 Package fios_sched_pkg holds WORD_W=17, the state enum type and the requester-id type.
REQ-033 Sub-module fios_rr_arb: 2-way round-robin arbiter with an update strobe.

Verification
REQ-034 S=8, req_i=01, 8 beats b=1..8 -> gnt_o=01, mm_start_o one cycle after beat 8, busy_o high.
REQ-035 req_i=11 from reset -> requester 0 granted; after done_i, requester 1 granted; req_i=11 again -> requester 0 granted.
REQ-036 In RUN, 9 b_fetch_i pulses -> b_o sequence 1..8,1 (wrap).
REQ-037 8 res_push_i with res_i=0x100..0x107 -> res_data_o same values one cycle later, res_last_o only on 0x107, res_id_o matches grant; a 9th push -> err_o=1.
REQ-038 done_i pulse in IDLE -> err_o=1, no grant change; reset asserted in RUN -> all outputs at reset values immediately.
REQ-039 With FIOS_SCHED_WDOG_EN defined and TIMEOUT_CYC=16, no done_i -> err_o=1 and IDLE 16 cycles after START.
